// File: rtl/stack_arbiter_pkg.sv
// Shared types for stack_arbiter: FSM state encoding and request opcodes.
package stack_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/stack_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick. Scans upward from ptr_i with
// wrap and returns the first set request as one-hot, encoded index and any.
module rr_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;
  logic           found;

  // First pending request at or after ptr_i, wrapping.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one LIFO between NREQ requesters. One request is
// granted at a time (round robin), turned into a single push/pop strobe and
// answered with one response. All outputs are registered.
// Optional error counter output err_cnt: define STACK_ARBITER_ERR_COUNT_EN.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BANDWIDTH = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ*BANDWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [BANDWIDTH-1:0]      rsp_data,
  output logic                      rsp_err,
  input  logic                      rsp_ready,
  output logic                      stk_push,
  output logic                      stk_pop,
  output logic [BANDWIDTH-1:0]      stk_data_in,
  input  logic [BANDWIDTH-1:0]      stk_data_out,
  input  logic                      stk_full,
`ifdef STACK_ARBITER_ERR_COUNT_EN
  output logic [7:0]                err_cnt,
`endif
  input  logic                      stk_empty
);

  state_e                 state_q;
  logic [IDW-1:0]         rr_ptr_q, id_q, ptr_d, arb_ptr;
  logic                   op_q, err_q;
  logic [BANDWIDTH-1:0]   data_q;
  logic [NREQ-1:0]        req_ready_q, gnt;
  logic [IDW-1:0]         gnt_idx;
  logic                   any_req;
  logic                   rsp_valid_q, rsp_err_q, stk_push_q, stk_pop_q;
  logic [IDW-1:0]         rsp_id_q;
  logic [BANDWIDTH-1:0]   rsp_data_q, stk_data_in_q;

  // Pointer after the current transaction; used on the handshake edge so the
  // next grant is already pending when the FSM lands in IDLE.
  assign ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
  assign arb_ptr = (state_q == RESP) ? ptr_d : rr_ptr_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i (req_valid),
    .ptr_i (arb_ptr),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_req)
  );

  // Transaction FSM: grant -> accept/strobe -> (wait for read data) -> respond.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      op_q          <= OP_PUSH;
      err_q         <= 1'b0;
      data_q        <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_ready_q != '0) begin
            // Accept edge: the strobe is registered here so it is high for
            // the whole ISSUE cycle.
            req_ready_q <= '0;
            state_q     <= ISSUE;
            if (op_q == OP_PUSH) begin
              err_q <= stk_full;
              if (!stk_full) begin
                stk_push_q    <= 1'b1;
                stk_data_in_q <= data_q;
              end
            end else begin
              err_q <= stk_empty;
              if (!stk_empty) stk_pop_q <= 1'b1;
            end
          end else if (any_req) begin
            req_ready_q <= gnt;
            op_q        <= req_op[gnt_idx];
            data_q      <= req_data[gnt_idx*BANDWIDTH +: BANDWIDTH];
            id_q        <= gnt_idx;
          end
        end
        ISSUE: begin
          stk_push_q    <= 1'b0;
          stk_pop_q     <= 1'b0;
          stk_data_in_q <= '0;
          if (op_q == OP_POP && !err_q) begin
            state_q <= WAIT;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= err_q;
            rsp_data_q  <= '0;
          end
        end
        WAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= stk_data_out;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ptr_d;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            if (any_req) begin
              req_ready_q <= gnt;
              op_q        <= req_op[gnt_idx];
              data_q      <= req_data[gnt_idx*BANDWIDTH +: BANDWIDTH];
              id_q        <= gnt_idx;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STACK_ARBITER_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  // Count rejected requests at their response handshake, saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_cnt_q <= '0;
    else if (state_q == RESP && rsp_ready && rsp_err_q && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign stk_push    = stk_push_q;
  assign stk_pop     = stk_pop_q;
  assign stk_data_in = stk_data_in_q;

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

- Shares one LIFO stack instance (DEPTH/BANDWIDTH-parameterised, push/pop/full/empty port set) between NREQ requesters.
- Each requester issues a push or pop request. A round-robin grant selects one request at a time. The block drives the stack's push/pop strobes and returns one response per request: popped data, or an error for push-when-full or pop-when-empty.
- It sits between the requester-side logic and the stack, and is the only driver of the stack's control inputs.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- BANDWIDTH, 4, data width; must match the stack
- IDW, $clog2(NREQ), derived requester-id width; not overridden

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_op  in  NREQ  0 = push, 1 = pop, one bit per requester
- req_data  in  NREQ*BANDWIDTH  push data; requester i uses bits [i*BANDWIDTH +: BANDWIDTH]
- req_ready  out  NREQ  one-hot accept pulse
- rsp_valid  out  1  response available
- rsp_id  out  IDW  index of the requester being answered
- rsp_data  out  BANDWIDTH  popped value; 0 for pushes and for errors
- rsp_err  out  1  request rejected (push with full, or pop with empty)
- rsp_ready  in  1  response consumer accepts
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_data_in  out  BANDWIDTH  stack write data
- stk_data_out  in  BANDWIDTH  stack read data
- stk_full  in  1  stack full flag
- stk_empty  in  1  stack empty flag

## Operation
Stack contract:
- push/pop are sampled on the rising edge.
- data_out is registered and valid in the cycle after the edge that sampled pop.
- full/empty reflect the state after the last sampled op.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any req_valid is set, grant the first set bit at or after rr_ptr, scanning upward and wrapping.
  - Pulse req_ready[g] for one cycle.
  - Latch op, data and id; go to ISSUE.
- ISSUE, push:
  - stk_full=0: assert stk_push and stk_data_in for one cycle, set err=0, go to RESP.
  - stk_full=1: no strobe, set err=1, go to RESP.
- ISSUE, pop:
  - stk_empty=0: assert stk_pop for one cycle, go to WAIT.
  - stk_empty=1: no strobe, set err=1, data=0, go to RESP.
- WAIT: capture stk_data_out into rsp_data, go to RESP.
- RESP
  - Hold rsp_valid/rsp_id/rsp_data/rsp_err stable until rsp_ready=1.
  - On that handshake edge: rr_ptr = (id+1) mod NREQ, return to IDLE.
- Transaction rules:
  - Exactly one stack op per transaction.
  - stk_push and stk_pop are never asserted together.
  - No new grant is issued while a transaction is outstanding.
- Requester contract:
  - Hold req_valid/req_op/req_data until req_ready is seen.
  - A req_valid dropped before grant is never served.
- Reset (asynchronous, any state):
  - FSM to IDLE, rr_ptr=0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, stk_push, stk_pop, stk_data_in.
  - An in-flight transaction is dropped without a response.
  - The stack's own contents are not touched.

## Timing
- Accept occurs in IDLE at edge T, with req_ready high during the cycle before T.
- Push latency: stk_push high in T..T+1; rsp_valid high from T+1.
- Pop latency: stk_pop high in T..T+1; WAIT in T+1..T+2; rsp_valid from T+2.
- Error responses: rsp_valid from T+1; no stack strobe.
- Throughput: with rsp_ready tied high, one push per 3 cycles or one pop per 4 cycles (IDLE included).
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- STACK_ARBITER_ERR_COUNT_EN defined:
  - Adds output err_cnt (8 bits), reset 0.
  - Increments by 1 on each RESP handshake with rsp_err=1.
  - Saturates at 255.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Package stack_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the opcode constants OP_PUSH=1'b0, OP_POP=1'b1.
- Sub-module rr_arbiter (NREQ parameter):
  - inputs: req vector, rr_ptr;
  - outputs: one-hot grant, encoded index, any_req;
  - purely combinational; the FSM registers its result.

## Test plan
- Reset, then requester 0 pushes 1..8 into an empty DEPTH=8 stack -> eight responses with err=0, stk_full=1 after the last.
- 9th push of 4'b1001 -> rsp_err=1, no stk_push pulse, stack unchanged.
- Eight pops -> rsp_data = 8,7,...,1; 9th pop -> rsp_err=1, rsp_data=0, no stk_pop pulse.
- All four requesters hold req_valid from reset -> grants occur in order 0,1,2,3,0; rsp_id matches each grant.
- Hold rsp_ready=0 for 5 cycles during a pop response -> rsp fields stable and no new req_ready; release -> handshake, then the next grant.
- Assert rstn=0 during WAIT -> all outputs 0 immediately; after release, rr_ptr=0 and requester 0 wins a contended grant. With the macro defined, err_cnt=2 after the two error scenarios above.
